// File: rtl/rv_alu_md_stage.sv
// Execute-stage integer ALU with RV M-extension: single-cycle base/MUL ops and an
// iterative restoring divider (DIV_UNROLL quotient bits per cycle) that stalls upstream while busy.
module rv_alu_md_stage #(
   parameter int XLEN       = 32,
   parameter int DIV_UNROLL = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_ce,
   input  logic [4:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_stall,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_y,
   output logic [4:0]      o_rd_addr,
   output logic            o_wr_rd,
   output logic            o_ce,
   output logic            o_stall_from_alu
);

   localparam int SHW = $clog2(XLEN);
   localparam int N   = XLEN / DIV_UNROLL;
   localparam int CW  = $clog2(N + 1);

   localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2,  OP_SLT  = 5'd3;
   localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR    = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8,  OP_AND    = 5'd9,  OP_MUL   = 5'd10, OP_MULH = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU = 5'd15;
   localparam logic [4:0] OP_REM  = 5'd16, OP_REMU   = 5'd17;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state_reg, state_next;

   logic [XLEN-1:0] y_reg, alu_result, rs1_abs, rs2_abs, div_q, div_r, div_result;
   logic [4:0]      rd_reg, div_rd_reg;
   logic            wr_reg, ce_reg;
   logic            hold, accept, start_div, is_div, is_signed_div, is_rem_op;
   logic            rs2_zero, overflow, div_special, rs1_neg, rs2_neg, op_valid;
   logic            a_signed, b_signed;
   logic [SHW-1:0]  shamt;
   logic [2*XLEN-1:0] mul_a, mul_b, product;

   logic [XLEN-1:0] rem_reg, quo_reg, divisor_reg;
   logic [CW-1:0]   cnt_reg;
   logic            q_neg_reg, r_neg_reg, rem_sel_reg;

   assign hold          = ce_reg & i_stall;
   assign accept        = i_ce & (state_reg == IDLE) & ~hold & ~i_flush;
   assign is_div        = (i_op >= OP_DIV) && (i_op <= OP_REMU);
   assign is_signed_div = (i_op == OP_DIV) || (i_op == OP_REM);
   assign is_rem_op     = (i_op == OP_REM) || (i_op == OP_REMU);
   assign op_valid      = (i_op <= OP_REMU);
   assign rs2_zero      = (i_rs2 == '0);
   assign overflow      = is_signed_div && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
   assign div_special   = rs2_zero | overflow;
   assign start_div     = accept & is_div & ~div_special;
   assign shamt         = i_rs2[SHW-1:0];

   // One 2*XLEN multiplier serves all MUL variants by choosing operand extension.
   assign a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
   assign b_signed = (i_op == OP_MULH);
   assign mul_a    = {{XLEN{a_signed & i_rs1[XLEN-1]}}, i_rs1};
   assign mul_b    = {{XLEN{b_signed & i_rs2[XLEN-1]}}, i_rs2};
   assign product  = mul_a * mul_b;

   always_comb begin
      alu_result = '0;
      case (i_op)
         OP_ADD:    alu_result = i_rs1 + i_rs2;
         OP_SUB:    alu_result = i_rs1 - i_rs2;
         OP_SLL:    alu_result = i_rs1 << shamt;
         OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, ($signed(i_rs1) < $signed(i_rs2))};
         OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, (i_rs1 < i_rs2)};
         OP_XOR:    alu_result = i_rs1 ^ i_rs2;
         OP_SRL:    alu_result = i_rs1 >> shamt;
         OP_SRA:    alu_result = $signed(i_rs1) >>> shamt;
         OP_OR:     alu_result = i_rs1 | i_rs2;
         OP_AND:    alu_result = i_rs1 & i_rs2;
         OP_MUL:    alu_result = product[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: alu_result = product[2*XLEN-1:XLEN];
         // Only reached for the single-cycle special cases (divide by zero, signed overflow).
         OP_DIV, OP_DIVU: alu_result = rs2_zero ? '1 : i_rs1;
         OP_REM, OP_REMU: alu_result = rs2_zero ? i_rs1 : '0;
         default:   alu_result = '0;
      endcase
   end

   assign rs1_neg = is_signed_div & i_rs1[XLEN-1];
   assign rs2_neg = is_signed_div & i_rs2[XLEN-1];
   assign rs1_abs = rs1_neg ? -i_rs1 : i_rs1;
   assign rs2_abs = rs2_neg ? -i_rs2 : i_rs2;

   logic [DIV_UNROLL:0][XLEN-1:0] rem_st, quo_st;
   assign rem_st[0] = rem_reg;
   assign quo_st[0] = quo_reg;

   generate
      for (genvar gi = 0; gi < DIV_UNROLL; gi++) begin : g_div_step
         logic [XLEN:0]   shifted;
         logic [XLEN-1:0] diff;
         logic            ge;
         assign shifted         = {rem_st[gi], quo_st[gi][XLEN-1]};
         assign ge              = shifted >= {1'b0, divisor_reg};
         assign diff            = shifted[XLEN-1:0] - divisor_reg;
         assign rem_st[gi+1]    = ge ? diff : shifted[XLEN-1:0];
         assign quo_st[gi+1]    = {quo_st[gi][XLEN-2:0], ge};
      end
   endgenerate

   assign div_q      = q_neg_reg ? -quo_reg : quo_reg;
   assign div_r      = r_neg_reg ? -rem_reg : rem_reg;
   assign div_result = rem_sel_reg ? div_r : div_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         cnt_reg     <= '0;
         q_neg_reg   <= 1'b0;
         r_neg_reg   <= 1'b0;
         rem_sel_reg <= 1'b0;
         div_rd_reg  <= '0;
      end else if (i_flush) begin
         cnt_reg <= '0;
      end else if (start_div) begin
         rem_reg     <= '0;
         quo_reg     <= rs1_abs;
         divisor_reg <= rs2_abs;
         cnt_reg     <= CW'(N);
         q_neg_reg   <= rs1_neg ^ rs2_neg;
         r_neg_reg   <= rs1_neg;
         rem_sel_reg <= is_rem_op;
         div_rd_reg  <= i_rd_addr;
      end else if (state_reg == DIV) begin
         rem_reg <= rem_st[DIV_UNROLL];
         quo_reg <= quo_st[DIV_UNROLL];
         cnt_reg <= cnt_reg - CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (i_flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start_div) state_next = DIV;
            DIV:     if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    if (!hold) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         y_reg  <= '0;
         rd_reg <= '0;
         wr_reg <= 1'b0;
         ce_reg <= 1'b0;
      end else if (i_flush) begin
         ce_reg <= 1'b0;
         wr_reg <= 1'b0;
      end else if (state_reg == DONE && !hold) begin
         y_reg  <= div_result;
         rd_reg <= div_rd_reg;
         wr_reg <= (div_rd_reg != 5'd0);
         ce_reg <= 1'b1;
      end else if (accept && !start_div) begin
         y_reg  <= alu_result;
         rd_reg <= i_rd_addr;
         wr_reg <= op_valid && (i_rd_addr != 5'd0);
         ce_reg <= 1'b1;
      end else if (!i_stall) begin
         ce_reg <= 1'b0;
         wr_reg <= 1'b0;
      end
   end

   assign o_y              = y_reg;
   assign o_rd_addr        = rd_reg;
   assign o_wr_rd          = wr_reg;
   assign o_ce             = ce_reg;
   assign o_stall_from_alu = (state_reg != IDLE);

endmodule
